// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Divides the system clock down to a pixel enable, runs horizontal/vertical
// position counters and produces registered sync, active-video and
// line/frame markers that are always aligned with h_pos/v_pos.
module vga_timing_gen #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             adv;
  logic             h_wrap;
  logic             v_wrap;
  logic             pix_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             active_nxt;
  logic             line_nxt;
  logic             frame_nxt;

  // Next position: advance on the last clk of a pixel period, restart wins.
  always_comb begin
    adv     = (div_cnt == DIV_W'(DIV - 1));
    h_wrap  = (h_pos == CNT_W'(H_TOTAL - 1));
    v_wrap  = (v_pos == CNT_W'(V_TOTAL - 1));
    div_nxt = div_cnt + DIV_W'(1);
    h_nxt   = h_pos;
    v_nxt   = v_pos;
    if (adv) begin
      div_nxt = '0;
      h_nxt   = h_wrap ? '0 : h_pos + CNT_W'(1);
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : v_pos + CNT_W'(1);
      end
    end
    if (restart) begin
      div_nxt = '0;
      h_nxt   = '0;
      v_nxt   = '0;
    end
  end

  // Output decode from the next position so registers match the counters.
  always_comb begin
    pix_nxt    = (div_nxt == '0);
    hsync_nxt  = ((h_nxt >= CNT_W'(HS_BEG)) && (h_nxt < CNT_W'(HS_END))) ? H_POL : ~H_POL;
    vsync_nxt  = ((v_nxt >= CNT_W'(VS_BEG)) && (v_nxt < CNT_W'(VS_END))) ? V_POL : ~V_POL;
    active_nxt = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
    line_nxt   = pix_nxt && (h_nxt == '0);
    frame_nxt  = line_nxt && (v_nxt == '0);
  end

  // Counter and output registers; reset state is the first clk of pixel (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_pos       <= '0;
      v_pos       <= '0;
      pix_en      <= 1'b1;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      active      <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      div_cnt     <= div_nxt;
      h_pos       <= h_nxt;
      v_pos       <= v_nxt;
      pix_en      <= pix_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      active      <= active_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule
